// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state encoding, key code constants and helpers for the keypad encoder
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_REL_DB
    } state_t;

    localparam logic [7:0] KEY_0    = 8'h00;
    localparam logic [7:0] KEY_1    = 8'h01;
    localparam logic [7:0] KEY_2    = 8'h02;
    localparam logic [7:0] KEY_3    = 8'h03;
    localparam logic [7:0] KEY_4    = 8'h04;
    localparam logic [7:0] KEY_5    = 8'h05;
    localparam logic [7:0] KEY_6    = 8'h06;
    localparam logic [7:0] KEY_7    = 8'h07;
    localparam logic [7:0] KEY_8    = 8'h08;
    localparam logic [7:0] KEY_9    = 8'h09;
    localparam logic [7:0] KEY_A    = 8'h0A;
    localparam logic [7:0] KEY_B    = 8'h0B;
    localparam logic [7:0] KEY_C    = 8'h0C;
    localparam logic [7:0] KEY_D    = 8'h0D;
    localparam logic [7:0] KEY_STAR = 8'h0E;
    localparam logic [7:0] KEY_HASH = 8'h0F;
    // Outside the 0x00-0x0F code space, so it can never collide with a real key.
    localparam logic [7:0] KEY_NONE = 8'hFF;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/keypad_map.sv
// keypad_map: combinational row/column intersection to key code lookup
//   row_i  : row index 0..3 of the pressed intersection
//   col_i  : column index 0..3 of the pressed intersection
//   code_o : key code (digits 0x00-0x09, A-D 0x0A-0x0D, * 0x0E, # 0x0F)
module keypad_map
    import keypad_pkg::*;
(
    input  logic [1:0] row_i,
    input  logic [1:0] col_i,
    output logic [7:0] code_o
);

    always_comb begin
        code_o = KEY_NONE;
        case ({row_i, col_i})
            4'h0: code_o = KEY_1;
            4'h1: code_o = KEY_2;
            4'h2: code_o = KEY_3;
            4'h3: code_o = KEY_A;
            4'h4: code_o = KEY_4;
            4'h5: code_o = KEY_5;
            4'h6: code_o = KEY_6;
            4'h7: code_o = KEY_B;
            4'h8: code_o = KEY_7;
            4'h9: code_o = KEY_8;
            4'hA: code_o = KEY_9;
            4'hB: code_o = KEY_C;
            4'hC: code_o = KEY_STAR;
            4'hD: code_o = KEY_0;
            4'hE: code_o = KEY_HASH;
            4'hF: code_o = KEY_D;
            default: code_o = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: 4x4 matrix keypad scanner with ghost rejection, debounce and valid/ready key output
//   clk, rst  : system clock, synchronous active-high reset
//   row_in    : active-low keypad rows (asynchronous)
//   col_out   : active-low one-cold column drive
//   key_code  : accepted key code, key_valid marks it unconsumed, key_ready consumes it
//   key_held  : a debounced key is down
//   overflow  : one-cycle pulse when a press event is dropped because key_code is still pending
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [DW-1:0] div_q;
    logic [1:0]    col_q;
    logic [1:0]    hits_q, hits_d;
    logic [1:0]    hrow_q, hrow_d;
    logic [1:0]    hcol_q, hcol_d;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    key_q;
    logic [7:0]    code_q;
    logic          valid_q;
    logic          ovf_q;

    logic          sample;
    logic          frame_end;
    logic [3:0]    pressed;
    logic [2:0]    npress;
    logic [2:0]    hit_sum;
    logic [1:0]    first_row;
    logic [7:0]    map_code;
    logic [7:0]    cand;
    logic          db_last;
    logic          press_evt;

    // Rows are only trusted on the final cycle of a column dwell, after the
    // synchronizer has had the whole dwell to settle.
    always_comb begin
        sample    = div_q == DW'(SCAN_DIV - 1);
        frame_end = sample && col_q == 2'd3;
        pressed   = ~sync2_q;
        npress    = pop4(pressed);
        first_row = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
        hit_sum   = {1'b0, hits_q} + npress;
        // Hit count saturates at 2: anything beyond one intersection is ghosting.
        hits_d    = hit_sum >= 3'd2 ? 2'd2 : hit_sum[1:0];
        hrow_d    = (hits_q == 2'd0 && npress != 3'd0) ? first_row : hrow_q;
        hcol_d    = (hits_q == 2'd0 && npress != 3'd0) ? col_q : hcol_q;
    end

    keypad_map u_map (
        .row_i  (hrow_d),
        .col_i  (hcol_d),
        .code_o (map_code)
    );

    always_comb begin
        cand      = hits_d == 2'd1 ? map_code : KEY_NONE;
        db_last   = cnt_q == CW'(DEBOUNCE - 1);
        press_evt = frame_end && cand != KEY_NONE &&
                    ((state_q == ST_IDLE && DEBOUNCE == 1) ||
                     (state_q == ST_PRESS_DB && cand == key_q && db_last));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            div_q   <= '0;
            col_q   <= 2'd0;
            hits_q  <= 2'd0;
            hrow_q  <= 2'd0;
            hcol_q  <= 2'd0;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
            div_q   <= sample ? '0 : div_q + DW'(1);
            if (sample) begin
                col_q  <= col_q + 2'd1;
                hits_q <= frame_end ? 2'd0 : hits_d;
                hrow_q <= hrow_d;
                hcol_q <= hcol_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= KEY_NONE;
        end else if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (cand != KEY_NONE) begin
                        key_q   <= cand;
                        state_q <= DEBOUNCE == 1 ? ST_HELD : ST_PRESS_DB;
                        cnt_q   <= DEBOUNCE == 1 ? '0 : CW'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (cand == KEY_NONE) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cand != key_q) begin
                        key_q <= cand;
                        cnt_q <= CW'(1);
                    end else if (db_last) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (cand == KEY_NONE) begin
                        state_q <= DEBOUNCE == 1 ? ST_IDLE : ST_REL_DB;
                        cnt_q   <= DEBOUNCE == 1 ? '0 : CW'(1);
                    end
                end
                ST_REL_DB: begin
                    if (cand != KEY_NONE) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (db_last) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // A press event may reuse the slot in the same cycle it is being consumed;
    // otherwise a pending code wins and the new one is dropped with a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= KEY_0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= press_evt && valid_q && !key_ready;
            if (press_evt && (!valid_q || key_ready)) begin
                code_q  <= cand;
                valid_q <= 1'b1;
            end else if (valid_q && key_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign col_out   = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = state_q == ST_HELD || state_q == ST_REL_DB;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed self-checking bench for keypad_encoder (SCAN_DIV=4, DEBOUNCE=3)
module tb_keypad_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [7:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_held;
    logic        overflow;
    logic [15:0] keys = 16'h0000;
    int          total = 0;
    int          bad = 0;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        keys = 16'h0000;
        key_ready = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_col", {4'h0, col_out}, 8'h0E);
        check("rst_code", key_code, 8'h00);
        check("rst_valid", {7'd0, key_valid}, 8'h00);
        check("rst_held", {7'd0, key_held}, 8'h00);
        check("rst_ovf", {7'd0, overflow}, 8'h00);

        // '5' held, no consumer: event after the 3rd frame end (edge 48)
        rst = 1'b0;
        keys = 16'h0020;
        tick(47);
        check("a_valid_early", {7'd0, key_valid}, 8'h00);
        tick(1);
        check("a_valid", {7'd0, key_valid}, 8'h01);
        check("a_code", key_code, 8'h05);
        check("a_held", {7'd0, key_held}, 8'h01);
        tick(40);
        check("a_valid_hold", {7'd0, key_valid}, 8'h01);
        check("a_code_hold", key_code, 8'h05);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("a_consumed", {7'd0, key_valid}, 8'h00);
        keys = 16'h0000;
        tick(64);
        check("a_released", {7'd0, key_held}, 8'h00);
        check("a_no_reevent", {7'd0, key_valid}, 8'h00);

        // '8' one frame on, one off, then steady: single event at edge 80
        do_reset();
        keys = 16'h0200;
        tick(16);
        keys = 16'h0000;
        tick(16);
        keys = 16'h0200;
        tick(47);
        check("b_valid_early", {7'd0, key_valid}, 8'h00);
        tick(1);
        check("b_valid", {7'd0, key_valid}, 8'h01);
        check("b_code", key_code, 8'h08);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        tick(47);
        check("b_single_event", {7'd0, key_valid}, 8'h00);
        check("b_held", {7'd0, key_held}, 8'h01);
        keys = 16'h0000;
        tick(47);
        check("b_held_rel2", {7'd0, key_held}, 8'h01);
        tick(1);
        check("b_released", {7'd0, key_held}, 8'h00);

        // '1' and '2' together: ghosted, never an event
        do_reset();
        keys = 16'h0003;
        tick(64);
        check("c_valid", {7'd0, key_valid}, 8'h00);
        check("c_held", {7'd0, key_held}, 8'h00);

        // '9' pending, then 'A' press is dropped with overflow
        do_reset();
        keys = 16'h0400;
        tick(48);
        check("d_code9", key_code, 8'h09);
        keys = 16'h0000;
        tick(48);
        keys = 16'h0008;
        tick(47);
        check("d_ovf_early", {7'd0, overflow}, 8'h00);
        tick(1);
        check("d_ovf", {7'd0, overflow}, 8'h01);
        check("d_code_kept", key_code, 8'h09);
        tick(1);
        check("d_ovf_pulse", {7'd0, overflow}, 8'h00);
        check("d_valid", {7'd0, key_valid}, 8'h01);
        check("d_code_kept2", key_code, 8'h09);

        // reset during PRESS_DB of '#'
        do_reset();
        keys = 16'h4000;
        tick(40);
        rst = 1'b1;
        tick(1);
        check("e_col", {4'h0, col_out}, 8'h0E);
        check("e_code", key_code, 8'h00);
        check("e_valid", {7'd0, key_valid}, 8'h00);
        check("e_held", {7'd0, key_held}, 8'h00);
        check("e_ovf", {7'd0, overflow}, 8'h00);
        rst = 1'b0;
        tick(47);
        check("e_valid_early", {7'd0, key_valid}, 8'h00);
        tick(1);
        check("e_valid", {7'd0, key_valid}, 8'h01);
        check("e_code_hash", key_code, 8'h0F);

        // '7' pending, '0' event coincides with acceptance
        do_reset();
        keys = 16'h0100;
        tick(48);
        check("f_code7", key_code, 8'h07);
        keys = 16'h0000;
        tick(48);
        keys = 16'h2000;
        tick(47);
        check("f_code7_kept", key_code, 8'h07);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("f_code0", key_code, 8'h00);
        check("f_valid", {7'd0, key_valid}, 8'h01);
        check("f_ovf", {7'd0, overflow}, 8'h00);
        tick(1);
        check("f_valid_stay", {7'd0, key_valid}, 8'h01);
        check("f_ovf_stay", {7'd0, overflow}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
